// File: rtl/dma_pkg.sv
// Shared DMA definitions: tile geometry, bus widths and the FMO writer state encoding.
package dma_pkg;

    localparam int TOX        = 4;
    localparam int TOY        = 4;
    localparam int TOF        = 8;
    localparam int FMO_N_ELEM = TOX * TOY * TOF;
    localparam int FMO_ADDR_W = 8;
    localparam int EXT_ADDR_W = 32;
    localparam int DATA_W     = 16;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RUN,
        WR_DONE
    } wr_state_t;

endpackage

// File: rtl/dma_fifo2.sv
// Two-entry first-word-fall-through FIFO; an entry pushed into an empty FIFO is
// presented on the output in the same cycle and only stored if it is not popped.
module dma_fifo2 #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pass_through;
    logic         wr;
    logic         rd;

    always_comb begin
        out_valid    = (count_q != 2'd0) || push;
        out_data     = '0;
        if (count_q != 2'd0) begin
            out_data = mem_q[rd_ptr_q];
        end else if (push) begin
            out_data = push_data;
        end
        pass_through = (count_q == 2'd0) && push && pop;
        wr           = push && !pass_through;
        rd           = pop && (count_q != 2'd0);
        wr_ptr_d     = wr ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d     = rd ? ~rd_ptr_q : rd_ptr_q;
        count_d      = count_q + {1'b0, wr} - {1'b0, rd};
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        assign mem_d[gi] = (wr && (wr_ptr_q == 1'(gi))) ? push_data : mem_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dma_fmo_writer.sv
// Output feature-map write-back DMA: drains the FMO tile RAM in linear order and
// emits one valid/ready write beat per element together with its external address.
module dma_fmo_writer #(
    parameter int DATA_W     = dma_pkg::DATA_W,
    parameter int EXT_ADDR_W = dma_pkg::EXT_ADDR_W,
    parameter int FMO_N_ELEM = dma_pkg::FMO_N_ELEM,
    parameter int FMO_ADDR_W = dma_pkg::FMO_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [EXT_ADDR_W-1:0] base_addr,
    input  logic [15:0]           row_stride,
    input  logic [EXT_ADDR_W-1:0] fmap_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  fmo_rd_en,
    output logic [FMO_ADDR_W-1:0] fmo_rd_addr,
    input  logic [DATA_W-1:0]     fmo_rd_data,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [EXT_ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0]     mem_wr_data
);

    import dma_pkg::*;

    localparam int XW    = (TOX > 1) ? $clog2(TOX) : 1;
    localparam int YW    = (TOY > 1) ? $clog2(TOY) : 1;
    localparam int CNT_W = $clog2(FMO_N_ELEM + 1);

    wr_state_t             state_q, state_d;
    logic [CNT_W-1:0]      elem_cnt_q, elem_cnt_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [EXT_ADDR_W-1:0] row_acc_q, row_acc_d;
    logic [EXT_ADDR_W-1:0] plane_acc_q, plane_acc_d;
    logic [15:0]           row_stride_q, row_stride_d;
    logic [EXT_ADDR_W-1:0] fmap_stride_q, fmap_stride_d;
    logic                  inflight_q, inflight_d;
    logic [EXT_ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic                  rd_en;
    logic                  pop;
    logic [2:0]            occ;
    logic [1:0]            fifo_count;

    always_comb begin
        state_d       = state_q;
        elem_cnt_d    = elem_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        row_acc_d     = row_acc_q;
        plane_acc_d   = plane_acc_q;
        row_stride_d  = row_stride_q;
        fmap_stride_d = fmap_stride_q;
        pend_addr_d   = pend_addr_q;

        pop   = mem_wr_valid && mem_wr_ready;
        // Slots that will be occupied next cycle if no new read is issued.
        occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en = (state_q == WR_RUN) && (elem_cnt_q < CNT_W'(FMO_N_ELEM)) && (occ < 3'd2);
        inflight_d = rd_en;

        unique case (state_q)
            WR_IDLE: begin
                if (start) begin
                    state_d       = WR_RUN;
                    elem_cnt_d    = '0;
                    beat_cnt_d    = '0;
                    x_d           = '0;
                    y_d           = '0;
                    row_acc_d     = base_addr;
                    plane_acc_d   = base_addr;
                    row_stride_d  = row_stride;
                    fmap_stride_d = fmap_stride;
                end
            end
            WR_RUN: begin
                if (rd_en) begin
                    pend_addr_d = row_acc_q + EXT_ADDR_W'(x_q);
                    elem_cnt_d  = elem_cnt_q + 1'b1;
                    if (x_q == XW'(TOX - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(TOY - 1)) begin
                            y_d         = '0;
                            plane_acc_d = plane_acc_q + fmap_stride_q;
                            row_acc_d   = plane_acc_q + fmap_stride_q;
                        end else begin
                            y_d       = y_q + 1'b1;
                            row_acc_d = row_acc_q + EXT_ADDR_W'(row_stride_q);
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == CNT_W'(FMO_N_ELEM - 1)) begin
                        state_d = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WR_IDLE;
            elem_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            x_q           <= '0;
            y_q           <= '0;
            row_acc_q     <= '0;
            plane_acc_q   <= '0;
            row_stride_q  <= '0;
            fmap_stride_q <= '0;
            inflight_q    <= 1'b0;
            pend_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            elem_cnt_q    <= elem_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            row_acc_q     <= row_acc_d;
            plane_acc_q   <= plane_acc_d;
            row_stride_q  <= row_stride_d;
            fmap_stride_q <= fmap_stride_d;
            inflight_q    <= inflight_d;
            pend_addr_q   <= pend_addr_d;
        end
    end

    // The address waits one cycle in pend_addr_q so it joins the RAM data it belongs to.
    dma_fifo2 #(
        .W(EXT_ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({pend_addr_q, fmo_rd_data}),
        .pop       (pop),
        .out_valid (mem_wr_valid),
        .out_data  ({mem_wr_addr, mem_wr_data}),
        .count     (fifo_count)
    );

    assign fmo_rd_en   = rd_en;
    assign fmo_rd_addr = rd_en ? FMO_ADDR_W'(elem_cnt_q) : '0;
    assign busy        = (state_q != WR_IDLE);
    assign done        = (state_q == WR_DONE);

endmodule

// File: tb/tb_dma_fmo_writer.sv
// Scoreboard bench for dma_fmo_writer: expected {addr, data} beats are queued at start,
// a negedge monitor pops and compares every accepted beat.
module tb_dma_fmo_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] row_stride;
    logic [31:0] fmap_stride;
    logic        busy;
    logic        done;
    logic        fmo_rd_en;
    logic [7:0]  fmo_rd_addr;
    logic [15:0] fmo_rd_data;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [15:0] mem_wr_data;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          beat_idx = 0;
    int          rd_issued = 0;
    int          max_out = 0;
    int          first_v_cyc = -1;
    logic [31:0] beat16_addr = 32'hFFFF_FFFF;
    int          rdy_mode = 0;
    int          stall_left = 0;
    bit          stall_taken = 1'b0;
    logic [47:0] exp_q [$];
    logic [47:0] mon_exp;
    logic        hold_v = 1'b0;
    logic [31:0] hold_a;
    logic [15:0] hold_d;
    logic        done_prev = 1'b0;
    logic [15:0] ram [0:255];

    always #5 clk = ~clk;

    dma_fmo_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .row_stride   (row_stride),
        .fmap_stride  (fmap_stride),
        .busy         (busy),
        .done         (done),
        .fmo_rd_en    (fmo_rd_en),
        .fmo_rd_addr  (fmo_rd_addr),
        .fmo_rd_data  (fmo_rd_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // FMO RAM model: data = address, registered read.
    always @(posedge clk) begin
        if (fmo_rd_en) fmo_rd_data <= ram[fmo_rd_addr];
    end

    // Ready generator: 0 = always ready, 1 = random, 2 = ready with one 20-cycle stall after beat 5.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            mem_wr_ready = 1'($urandom_range(0, 1));
        end else if (rdy_mode == 2) begin
            if (!stall_taken && beat_idx == 6) begin
                stall_taken  = 1'b1;
                stall_left   = 19;
                mem_wr_ready = 1'b0;
            end else if (stall_left > 0) begin
                stall_left   = stall_left - 1;
                mem_wr_ready = 1'b0;
            end else begin
                mem_wr_ready = 1'b1;
            end
        end else begin
            stall_taken  = 1'b0;
            mem_wr_ready = 1'b1;
        end
    end

    // Monitor: beat scoreboard, stall stability, single-cycle done, outstanding-read bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v    = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                checks++;
                if (done || busy) begin
                    errors++;
                    $display("FAIL done_single_pulse: done=%0b busy=%0b, required done=0 busy=0", done, busy);
                end
            end
            done_prev = done;
            if (hold_v) begin
                checks++;
                if (!mem_wr_valid || mem_wr_addr != hold_a || mem_wr_data != hold_d) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%0b addr=%h data=%h, required valid=1 addr=%h data=%h",
                             mem_wr_valid, mem_wr_addr, mem_wr_data, hold_a, hold_d);
                end
            end
            hold_v = mem_wr_valid && !mem_wr_ready;
            hold_a = mem_wr_addr;
            hold_d = mem_wr_data;
            if (mem_wr_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (fmo_rd_en) rd_issued++;
            if (mem_wr_valid && mem_wr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: addr=%h data=%h, required no beat", mem_wr_addr, mem_wr_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({mem_wr_addr, mem_wr_data} != mon_exp) begin
                        errors++;
                        $display("FAIL beat_%0d: addr=%h data=%h, required addr=%h data=%h",
                                 beat_idx, mem_wr_addr, mem_wr_data, mon_exp[47:16], mon_exp[15:0]);
                    end
                end
                if (beat_idx == 16) beat16_addr = mem_wr_addr;
                beat_idx++;
            end
            if (rd_issued - beat_idx > max_out) max_out = rd_issued - beat_idx;
        end
    end

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input logic [15:0] rs,
                                             input logic [31:0] fs, input int k);
        logic [31:0] x, y, f;
        x = 32'(k % 4);
        y = 32'((k / 4) % 4);
        f = 32'(k / 16);
        return b + f * fs + y * {16'h0000, rs} + x;
    endfunction

    task automatic check_zero(input string name);
        checks++;
        if ({busy, done, fmo_rd_en, fmo_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data} != '0) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b rd_en=%0b rd_addr=%0d valid=%0b addr=%h data=%h, required all 0",
                     name, busy, done, fmo_rd_en, fmo_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One tile transfer. exp_lat > 0 checks start-to-done latency; inj_beat >= 0 pulses a
    // stray start at that beat; rst_beat >= 0 asserts reset at that beat and aborts.
    task automatic run_xfer(input string name, input logic [31:0] b, input logic [15:0] rs,
                            input logic [31:0] fs, input int exp_lat, input int inj_beat,
                            input int rst_beat);
        int c0;
        int done_cyc;
        bit got;
        bit inj_done;
        bit aborted;
        got = 1'b0; inj_done = 1'b0; aborted = 1'b0; done_cyc = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 128; k++) exp_q.push_back({exp_addr(b, rs, fs, k), 16'(k)});
        beat_idx = 0; rd_issued = 0; max_out = 0; first_v_cyc = -1;
        base_addr = b; row_stride = rs; fmap_stride = fs; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 32'hA5A5_A5A5; row_stride = 16'h0007; fmap_stride = 32'h0000_0333;
        for (int t = 0; t < 3000 && !got && !aborted; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
            end else if (inj_beat >= 0 && !inj_done && beat_idx >= inj_beat) begin
                inj_done = 1'b1;
                @(posedge clk); #1;
                start = 1'b1; base_addr = 32'hDEAD_0000;
                @(posedge clk); #1;
                start = 1'b0;
            end else if (rst_beat >= 0 && beat_idx >= rst_beat) begin
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                check_zero("reset_mid_xfer");
                exp_q.delete();
                @(negedge clk); #2;
                rst_n = 1'b1;
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            $display("xfer %s: base=%h aborted by reset after %0d beats", name, b, beat_idx);
            return;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: done not seen, beats=%0d, required done", name, beat_idx);
        end else begin
            if (exp_lat > 0) check_int({name, "_done_latency"}, done_cyc - c0, exp_lat);
            check_int({name, "_first_beat_latency"}, first_v_cyc - c0, 2);
            check_int({name, "_beats_left"}, exp_q.size(), 0);
            checks++;
            if (max_out > 2) begin
                errors++;
                $display("FAIL %s_outstanding: got %0d, required at most 2", name, max_out);
            end
        end
        $display("xfer %s: base=%h beats=%0d done_latency=%0d max_outstanding=%0d",
                 name, b, beat_idx, done_cyc - c0, max_out);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; row_stride = '0; fmap_stride = '0;
        mem_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("idle_after_reset");

        rdy_mode = 0;
        run_xfer("full_ready", 32'h0000_1000, 16'd64, 32'd4096, 130, -1, -1);
        rdy_mode = 1;
        run_xfer("random_ready", 32'h0000_1000, 16'd64, 32'd4096, -1, -1, -1);
        rdy_mode = 2;
        run_xfer("stall20", 32'h0000_1000, 16'd64, 32'd4096, 150, -1, -1);
        rdy_mode = 0;
        run_xfer("stray_start", 32'h0000_1000, 16'd64, 32'd4096, 130, 40, -1);
        run_xfer("back_to_back", 32'h0040_0000, 16'd128, 32'd8192, 130, -1, -1);
        run_xfer("wrap", 32'hFFFF_FFF0, 16'd4, 32'd16, 130, -1, -1);
        checks++;
        if (beat16_addr != 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_elem16_addr: got %h, required 00000000", beat16_addr);
        end
        run_xfer("reset_abort", 32'h0000_3000, 16'd64, 32'd4096, -1, -1, 50);
        @(negedge clk);
        check_zero("idle_after_abort");
        run_xfer("after_reset", 32'h5000_0000, 16'd32, 32'd1024, 130, -1, -1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
